// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types for the EXU <-> data-memory handshake: FSM states, bus widths and the request bundle.
package ysyx_22050612_mem_pkg;

  localparam int MEM_BYTES  = 8;
  localparam int MEM_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                   wen;
    logic [MEM_ADDR_W-1:0]  addr;
    logic [8*MEM_BYTES-1:0] wdata;
    logic [MEM_BYTES-1:0]   wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22050612_bytemask_ram.sv
// Doubleword RAM with a synchronous byte-enabled write port and a combinational read port.
module ysyx_22050612_bytemask_ram
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  idx,
  input  logic [8*MEM_BYTES-1:0] wdata,
  input  logic [MEM_BYTES-1:0]   wmask,
  output logic [8*MEM_BYTES-1:0] rdata
);

  logic [MEM_BYTES-1:0][7:0] mem [2**DEPTH_LOG2];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MEM_BYTES; b++) begin
        if (wmask[b]) mem[idx][b] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22050612_dmem_responder.sv
// Fixed-latency data-memory responder for the EXU load/store port (one request in flight).
// Optional DMEM_RANGE_CHECK_EN: out-of-window addresses fault instead of aliasing.
module ysyx_22050612_dmem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wen,
  input  logic [MEM_ADDR_W-1:0]  req_addr,
  input  logic [8*MEM_BYTES-1:0] req_wdata,
  input  logic [MEM_BYTES-1:0]   req_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*MEM_BYTES-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t                   state, state_nxt;
  mem_req_t                 req_q;
  logic [CNT_W-1:0]         cnt;
  logic [MEM_ADDR_W-1:0]    off;
  logic [DEPTH_LOG2-1:0]    idx;
  logic                     in_range, fire, commit, ram_we;
  logic [8*MEM_BYTES-1:0]   ram_rdata;
  logic                     unused_bits;

  assign req_ready = (state == IDLE) && !rst;
  assign fire      = req_valid && req_ready;
  assign commit    = (state == WAIT) && (cnt == '0);

  assign off = req_q.addr - BASE_ADDR;
  assign idx = off[DEPTH_LOG2+2:3];

`ifdef DMEM_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to a huge offset and fail this test too.
  assign in_range    = (off[MEM_ADDR_W-1:DEPTH_LOG2+3] == '0);
  assign unused_bits = ^off[2:0];
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{off[MEM_ADDR_W-1:DEPTH_LOG2+3], off[2:0]};
`endif

  // Gated by rst so a write caught in WAIT by reset is never committed.
  assign ram_we = commit && req_q.wen && in_range && !rst;

  ysyx_22050612_bytemask_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx),
    .wdata (req_q.wdata),
    .wmask (req_q.wmask),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire)          state_nxt = WAIT;
      WAIT:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (fire) begin
        req_q <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
        cnt   <= CNT_W'(LATENCY - 1);
      end
      if ((state == WAIT) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !in_range;
        rsp_rdata <= (!req_q.wen && in_range) ? ram_rdata : '0;
      end
      if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
